// File: rtl/vec_pkg.sv
// Shared widths, FSM state encoding and beat-count helper for the vector packer.
package vec_pkg;

    localparam int LANE_W    = 8;
    localparam int BUS_W     = 128;
    localparam int MAX_LANES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic int beats(input int elems, input int lanes);
        return (elems + lanes - 32'sd1) / lanes;
    endfunction

endpackage

// File: rtl/vec_lane_insert.sv
// Combinational write of one 8-bit element into a selected lane of a 128-bit beat.
module vec_lane_insert
    import vec_pkg::*;
(
    input  logic [BUS_W-1:0]  data_i,
    input  logic [3:0]        lane_i,
    input  logic [LANE_W-1:0] val_i,
    output logic [BUS_W-1:0]  data_o
);

    // Replace only the addressed lane; every other lane passes through unchanged.
    always_comb begin
        data_o = data_i;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (lane_i == 4'(k)) begin
                data_o[k*LANE_W +: LANE_W] = val_i;
            end else begin
                data_o[k*LANE_W +: LANE_W] = data_i[k*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/vec_stream_packer.sv
// Packs a serial stream of INT8 pairs into zero-padded 128-bit beats, ELEMS per frame.
// Define VEC_PACKER_ERR_EN to add the sticky err_drop flag for stray in_valid.
module vec_stream_packer
    import vec_pkg::*;
#(
    parameter int ELEMS = 1000,
    parameter int LANES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_a,
    input  logic [LANE_W-1:0] in_b,
    output logic              vec_valid,
    output logic [BUS_W-1:0]  vec_a,
    output logic [BUS_W-1:0]  vec_b,
    output logic              busy,
    output logic              frame_done
`ifdef VEC_PACKER_ERR_EN
    ,
    output logic              err_drop
`endif
);

    localparam int             CW        = $clog2(ELEMS + 1);
    localparam logic [CW-1:0]  LAST_ELEM = CW'(ELEMS - 1);
    localparam logic [3:0]     LAST_LANE = 4'(LANES - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      elem_cnt_q, elem_cnt_d;
    logic [3:0]         lane_idx_q, lane_idx_d;
    logic [BUS_W-1:0]   fill_a_q, fill_a_d;
    logic [BUS_W-1:0]   fill_b_q, fill_b_d;
    logic [BUS_W-1:0]   vec_a_q, vec_a_d;
    logic [BUS_W-1:0]   vec_b_q, vec_b_d;
    logic               vec_valid_q, vec_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               in_ready_q;
    logic               busy_q;
    logic [BUS_W-1:0]   ins_a_s, ins_b_s;
    logic               beat_done_s;

    vec_lane_insert u_ins_a (
        .data_i (fill_a_q),
        .lane_i (lane_idx_q),
        .val_i  (in_a),
        .data_o (ins_a_s)
    );

    vec_lane_insert u_ins_b (
        .data_i (fill_b_q),
        .lane_i (lane_idx_q),
        .val_i  (in_b),
        .data_o (ins_b_s)
    );

    assign beat_done_s = (lane_idx_q == LAST_LANE) || (elem_cnt_q == LAST_ELEM);

    // Next-state and datapath decisions for the IDLE/RUN/FLUSH framing FSM.
    always_comb begin
        state_d      = state_q;
        elem_cnt_d   = elem_cnt_q;
        lane_idx_d   = lane_idx_q;
        fill_a_d     = fill_a_q;
        fill_b_d     = fill_b_q;
        vec_a_d      = vec_a_q;
        vec_b_d      = vec_b_q;
        vec_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    elem_cnt_d = '0;
                    lane_idx_d = 4'd0;
                    fill_a_d   = '0;
                    fill_b_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (in_valid) begin
                    elem_cnt_d = elem_cnt_q + CW'(1);
                    if (beat_done_s) begin
                        // The completing lane goes straight to the output, bypassing the fill register.
                        vec_a_d     = ins_a_s;
                        vec_b_d     = ins_b_s;
                        vec_valid_d = 1'b1;
                        fill_a_d    = '0;
                        fill_b_d    = '0;
                        lane_idx_d  = 4'd0;
                        if (elem_cnt_q == LAST_ELEM) begin
                            frame_done_d = 1'b1;
                            state_d      = FLUSH;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        fill_a_d   = ins_a_s;
                        fill_b_d   = ins_b_s;
                        lane_idx_d = lane_idx_q + 4'd1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, fill and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            elem_cnt_q   <= '0;
            lane_idx_q   <= 4'd0;
            fill_a_q     <= '0;
            fill_b_q     <= '0;
            vec_a_q      <= '0;
            vec_b_q      <= '0;
            vec_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            elem_cnt_q   <= elem_cnt_d;
            lane_idx_q   <= lane_idx_d;
            fill_a_q     <= fill_a_d;
            fill_b_q     <= fill_b_d;
            vec_a_q      <= vec_a_d;
            vec_b_q      <= vec_b_d;
            vec_valid_q  <= vec_valid_d;
            frame_done_q <= frame_done_d;
            in_ready_q   <= (state_d == RUN);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign vec_valid  = vec_valid_q;
    assign vec_a      = vec_a_q;
    assign vec_b      = vec_b_q;
    assign frame_done = frame_done_q;

`ifdef VEC_PACKER_ERR_EN
    logic err_drop_q;

    // Sticky record of any element offered while the packer could not accept it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_drop_q <= 1'b0;
        end else if (in_valid && !in_ready_q) begin
            err_drop_q <= 1'b1;
        end
    end

    assign err_drop = err_drop_q;
`endif

endmodule
